// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-style fetch and data ports onto one AXI3 master, one single-beat transaction at a time.
// Optional BRIDGE_KSEG_MAP_EN folds kseg0/kseg1 addresses down to physical addresses.
module sram_axi_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_stall,
  input  logic        data_sram_en,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_stall,
  input  logic        longest_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_W, D_B} state_t;

  state_t state;
  logic   inst_ok;
  logic   data_ok;

  // Only one transaction is ever outstanding, so response IDs and status carry no information.
  logic unused;
  assign unused = ^{rid, rresp, rlast, bid, bresp};

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    map_addr = a & 32'hFFFF_FFFC;
`ifdef BRIDGE_KSEG_MAP_EN
    if (a[31:30] == 2'b10) map_addr = a & 32'h1FFF_FFFC;
`endif
  endfunction

  assign arlen   = 4'd0;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd1;
  assign awlen   = 4'd0;
  assign awsize  = 3'd2;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;

  assign inst_stall = inst_sram_en & ~inst_ok;
  assign data_stall = data_sram_en & ~data_ok;

  // An ok flag only survives while the pipeline is frozen; a completion seen while it advances is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awvalid         <= 1'b0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
      arid            <= 4'd0;
      araddr          <= 32'd0;
      awaddr          <= 32'd0;
      wdata           <= 32'd0;
      wstrb           <= 4'd0;
      inst_ok         <= 1'b0;
      data_ok         <= 1'b0;
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      if (!longest_stall) begin
        inst_ok <= 1'b0;
        data_ok <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (data_sram_en && !data_ok) begin
            if (data_sram_wen == 4'd0) begin
              state   <= D_AR;
              arvalid <= 1'b1;
              arid    <= 4'd1;
              araddr  <= map_addr(data_sram_addr);
            end else begin
              state   <= D_W;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= map_addr(data_sram_addr);
              wdata   <= data_sram_wdata;
              wstrb   <= data_sram_wen;
            end
          end else if (inst_sram_en && !inst_ok) begin
            state   <= I_AR;
            arvalid <= 1'b1;
            arid    <= 4'd0;
            araddr  <= map_addr(inst_sram_addr);
          end
        end
        I_AR, D_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= (state == I_AR) ? I_R : D_R;
          end
        end
        I_R: begin
          if (rvalid) begin
            rready          <= 1'b0;
            inst_sram_rdata <= rdata;
            if (longest_stall) inst_ok <= 1'b1;
            state           <= IDLE;
          end
        end
        D_R: begin
          if (rvalid) begin
            rready          <= 1'b0;
            data_sram_rdata <= rdata;
            if (longest_stall) data_ok <= 1'b1;
            state           <= IDLE;
          end
        end
        D_W: begin
          // AW and W may complete in either order; move on once neither is still pending.
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= D_B;
          end
        end
        D_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (longest_stall) data_ok <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a small AXI slave model; expectations follow BRIDGE_KSEG_MAP_EN.
`timescale 1ns/1ps
module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_stall;
  logic        data_sram_en;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_stall;
  logic        longest_stall;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        rlast;
  logic        hold;

`ifdef BRIDGE_KSEG_MAP_EN
  localparam logic [31:0] FETCH_ADDR = 32'h1FC0_0000;
  localparam logic [31:0] STORE_ADDR = 32'h0000_0010;
  localparam logic [31:0] LOAD_ADDR  = 32'h0000_0104;
  localparam logic [31:0] LOAD_DATA  = 32'hA5A5_0104;
  localparam logic [31:0] SIM_IADDR  = 32'h1FC0_0010;
  localparam logic [31:0] SIM_IDATA  = 32'hBA65_0010;
`else
  localparam logic [31:0] FETCH_ADDR = 32'hBFC0_0000;
  localparam logic [31:0] STORE_ADDR = 32'h8000_0010;
  localparam logic [31:0] LOAD_ADDR  = 32'h8000_0104;
  localparam logic [31:0] LOAD_DATA  = 32'h25A5_0104;
  localparam logic [31:0] SIM_IADDR  = 32'hBFC0_0010;
  localparam logic [31:0] SIM_IDATA  = 32'h1A65_0010;
`endif

  int checks = 0;
  int errors = 0;

  int ar_delay, r_delay, aw_delay, w_delay;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;
  logic r_pending = 1'b0, aw_got = 1'b0, w_got = 1'b0, b_pending = 1'b0;
  logic [31:0] r_addr = 32'd0;
  logic [3:0] w_strb_seen = 4'd0;
  int ar_count = 0, aw_count = 0, w_count = 0, b_count = 0;
  logic [3:0] ar_ids[$];

  assign longest_stall = inst_stall | data_stall | hold;
  assign rid   = 4'd0;
  assign rresp = 2'b00;
  assign rlast = 1'b1;
  assign bid   = 4'd1;
  assign bresp = 2'b00;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .inst_stall(inst_stall),
    .data_sram_en(data_sram_en), .data_sram_addr(data_sram_addr),
    .data_sram_wen(data_sram_wen), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .data_stall(data_stall),
    .longest_stall(longest_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a[27:0] == 28'hFC0_0000) rd_word = 32'h2408_0001;
    else rd_word = a ^ 32'hA5A5_0000;
  endfunction

  // Slave: ready/valid driven on the falling edge, handshakes recorded on the rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      rdata = 32'd0; ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0;
    end else begin
      if (arvalid) begin arready = (ar_wait >= ar_delay); if (!arready) ar_wait++; end
      else begin arready = 1'b0; ar_wait = 0; end
      if (awvalid) begin awready = (aw_wait >= aw_delay); if (!awready) aw_wait++; end
      else begin awready = 1'b0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_delay); if (!wready) w_wait++; end
      else begin wready = 1'b0; w_wait = 0; end
      if (r_pending && r_wait >= r_delay) begin rvalid = 1'b1; rdata = rd_word(r_addr); end
      else begin rvalid = 1'b0; if (r_pending) r_wait++; else r_wait = 0; end
      bvalid = b_pending;
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      r_pending = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_pending = 1'b0;
    end else begin
      if (arvalid && arready) begin
        ar_count++; ar_ids.push_back(arid); r_pending = 1'b1; r_addr = araddr;
      end
      if (rvalid && rready) r_pending = 1'b0;
      if (awvalid && awready) begin aw_count++; aw_got = 1'b1; end
      if (wvalid && wready) begin w_count++; w_got = 1'b1; w_strb_seen = wstrb; end
      if (bvalid && bready) begin b_count++; b_pending = 1'b0; end
      if (aw_got && w_got) begin aw_got = 1'b0; w_got = 1'b0; b_pending = 1'b1; end
    end
  end

  task automatic test_reset();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_valids: got %b, expected 00000", {arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_rdata: got %h/%h, expected 0/0", inst_sram_rdata, data_sram_rdata);
    end
    checks++;
    if ({inst_stall, data_stall} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_stall_idle: got %b, expected 00", {inst_stall, data_stall});
    end
    inst_sram_en = 1'b1; data_sram_en = 1'b1;
    @(negedge clk);
    checks++;
    if ({inst_stall, data_stall, arvalid, awvalid} !== 4'b1100) begin
      errors++; $display("[TB] FAIL reset_stall_en: got %b, expected 1100", {inst_stall, data_stall, arvalid, awvalid});
    end
    inst_sram_en = 1'b0; data_sram_en = 1'b0;
  endtask

  task automatic test_fetch();
    int base;
    base = ar_count;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== FETCH_ADDR || arid !== 4'd0) begin
      errors++; $display("[TB] FAIL fetch_ar: got valid=%b addr=%h id=%h, expected 1 %h 0", arvalid, araddr, arid, FETCH_ADDR);
    end
    @(negedge clk);
    checks++;
    if (rready !== 1'b1 || inst_stall !== 1'b1) begin
      errors++; $display("[TB] FAIL fetch_r: got rready=%b stall=%b, expected 1 1", rready, inst_stall);
    end
    @(negedge clk);
    checks++;
    if (inst_stall !== 1'b0 || inst_sram_rdata !== 32'h2408_0001 || ar_count != base + 1) begin
      errors++; $display("[TB] FAIL fetch_done: got stall=%b rdata=%h ars=%0d, expected 0 24080001 %0d",
                         inst_stall, inst_sram_rdata, ar_count, base + 1);
    end
    inst_sram_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int base;
    base = b_count;
    aw_delay = 3; w_delay = 0;
    data_sram_en = 1'b1; data_sram_addr = 32'h8000_0011; data_sram_wen = 4'b0010; data_sram_wdata = 32'h0000_AB00;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid} !== 2'b11 || awaddr !== STORE_ADDR || wstrb !== 4'b0010 || wdata !== 32'h0000_AB00
        || awid !== 4'd1 || wid !== 4'd1) begin
      errors++; $display("[TB] FAIL store_aw_w: got v=%b addr=%h strb=%b data=%h ids=%h/%h, expected 11 %h 0010 0000ab00 1/1",
                         {awvalid, wvalid}, awaddr, wstrb, wdata, awid, wid, STORE_ADDR);
    end
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, data_stall} !== 3'b101) begin
      errors++; $display("[TB] FAIL store_w_first: got aw/w/stall=%b, expected 101", {awvalid, wvalid, data_stall});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bready !== 1'b1 || data_stall !== 1'b1 || b_count != base || awvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL store_b_wait: got bready=%b stall=%b bs=%0d awvalid=%b, expected 1 1 %0d 0",
                         bready, data_stall, b_count, awvalid, base);
    end
    @(negedge clk);
    checks++;
    if (data_stall !== 1'b0 || b_count != base + 1 || w_strb_seen !== 4'b0010) begin
      errors++; $display("[TB] FAIL store_done: got stall=%b bs=%0d strb=%b, expected 0 %0d 0010",
                         data_stall, b_count, w_strb_seen, base + 1);
    end
    data_sram_en = 1'b0; data_sram_wen = 4'd0; aw_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base;
    base = ar_count;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0010;
    data_sram_en = 1'b1; data_sram_addr = 32'h8000_0104; data_sram_wen = 4'd0;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== LOAD_ADDR) begin
      errors++; $display("[TB] FAIL b2b_data_first: got v=%b id=%h addr=%h, expected 1 1 %h", arvalid, arid, araddr, LOAD_ADDR);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({data_stall, inst_stall} !== 2'b01 || data_sram_rdata !== LOAD_DATA) begin
      errors++; $display("[TB] FAIL b2b_load_done: got d/i stall=%b rdata=%h, expected 01 %h",
                         {data_stall, inst_stall}, data_sram_rdata, LOAD_DATA);
    end
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== SIM_IADDR || data_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_inst_ar: got v=%b id=%h addr=%h dstall=%b, expected 1 0 %h 0",
                         arvalid, arid, araddr, data_stall, SIM_IADDR);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({inst_stall, data_stall} !== 2'b00 || inst_sram_rdata !== SIM_IDATA || data_sram_rdata !== LOAD_DATA
        || ar_count != base + 2 || ar_ids[base] !== 4'd1 || ar_ids[base + 1] !== 4'd0) begin
      errors++; $display("[TB] FAIL b2b_done: got stalls=%b irdata=%h drdata=%h ars=%0d, expected 00 %h %h %0d (ids 1,0)",
                         {inst_stall, data_stall}, inst_sram_rdata, data_sram_rdata, ar_count, SIM_IDATA, LOAD_DATA, base + 2);
    end
    inst_sram_en = 1'b0; data_sram_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold();
    int base;
    base = ar_count;
    hold = 1'b1;
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0040;
    repeat (3) @(negedge clk);
    checks++;
    if (inst_stall !== 1'b0 || inst_sram_rdata !== 32'hA5A5_0040) begin
      errors++; $display("[TB] FAIL hold_fetch: got stall=%b rdata=%h, expected 0 a5a50040", inst_stall, inst_sram_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_stall !== 1'b0 || arvalid !== 1'b0) begin
        errors++; $display("[TB] FAIL hold_cycle%0d: got stall=%b arvalid=%b, expected 0 0", i, inst_stall, arvalid);
      end
      @(negedge clk);
    end
    checks++;
    if (ar_count != base + 1) begin
      errors++; $display("[TB] FAIL hold_one_ar: got %0d, expected %0d", ar_count, base + 1);
    end
    hold = 1'b0; inst_sram_addr = 32'h0000_0044;
    repeat (2) @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_0044) begin
      errors++; $display("[TB] FAIL hold_next_ar: got v=%b addr=%h, expected 1 00000044", arvalid, araddr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (inst_stall !== 1'b0 || inst_sram_rdata !== 32'hA5A5_0044 || ar_count != base + 2) begin
      errors++; $display("[TB] FAIL hold_next_done: got stall=%b rdata=%h ars=%0d, expected 0 a5a50044 %0d",
                         inst_stall, inst_sram_rdata, ar_count, base + 2);
    end
    inst_sram_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (inst_sram_rdata !== 32'hA5A5_0044) begin
      errors++; $display("[TB] FAIL hold_rdata_kept: got %h, expected a5a50044", inst_sram_rdata);
    end
  endtask

  task automatic test_reset_in_flight();
    r_delay = 20;
    inst_sram_en = 1'b1; inst_sram_addr = 32'h0000_0080;
    repeat (2) @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("[TB] FAIL rif_in_r: got rready=%b, expected 1", rready);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_stall, data_stall} !== 7'b0000010) begin
      errors++; $display("[TB] FAIL rif_reset: got %b, expected 0000010",
                         {arvalid, rready, awvalid, wvalid, bready, inst_stall, data_stall});
    end
    repeat (2) @(negedge clk);
    r_delay = 0;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_0080 || inst_sram_rdata !== 32'd0) begin
      errors++; $display("[TB] FAIL rif_reissue: got v=%b addr=%h rdata=%h, expected 1 00000080 0", arvalid, araddr, inst_sram_rdata);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (inst_stall !== 1'b0 || inst_sram_rdata !== 32'hA5A5_0080) begin
      errors++; $display("[TB] FAIL rif_done: got stall=%b rdata=%h, expected 0 a5a50080", inst_stall, inst_sram_rdata);
    end
    inst_sram_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetn = 1'b0; hold = 1'b0;
    inst_sram_en = 1'b0; inst_sram_addr = 32'd0;
    data_sram_en = 1'b0; data_sram_addr = 32'd0; data_sram_wen = 4'd0; data_sram_wdata = 32'd0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    test_fetch();
    test_store();
    test_back_to_back();
    test_hold();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
